proj_fm_window_buf: RTL and testbench



---
 rtl/proj_pkg.sv | 12 +
 rtl/proj_fm_bank_ctrl.sv | 89 ++++++++
 rtl/proj_fm_window_buf.sv | 78 +++++++
 tb/tb_proj_fm_window_buf.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// Shared constants and types for the FM genome window buffer.
package proj_pkg;

  localparam int FM_GENOME_BTYE  = 8;
  localparam int FM_BANK_COUNT   = 2;
  localparam int FM_BANK_DEPTH   = 64;
  localparam int FM_WINDOW_COUNT = 4;

  typedef logic [$clog2(FM_BANK_COUNT)-1:0] fm_bank_idx_t;
  typedef logic [$clog2(FM_BANK_DEPTH):0]   fm_len_t;

endpackage

// File: rtl/proj_fm_bank_ctrl.sv
// Bank bookkeeping for the window buffer: write/read bank pointers, fill count,
// write address, bank close/release and per-bank valid-length registers.
module proj_fm_bank_ctrl
  import proj_pkg::*;
#(
  parameter int BANKS = FM_BANK_COUNT,
  parameter int DEPTH = FM_BANK_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1,
  localparam int BW = $clog2(BANKS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wvalid_i,
  input  logic          wflush_i,
  input  logic          rdone_i,
  output logic          wready_o,
  output logic          wr_en_o,
  output logic [BW-1:0] wr_bank_o,
  output logic [AW-1:0] wr_addr_o,
  output logic          ravail_o,
  output logic [BW-1:0] rd_bank_o,
  output logic [LW-1:0] rlen_o
);

  logic [BW-1:0] wr_bank_q, wr_bank_d;
  logic [BW-1:0] rd_bank_q, rd_bank_d;
  logic [BW:0]   filled_q, filled_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [LW-1:0] len_q [BANKS];
  logic          accept, close, rel;
  logic [LW-1:0] close_len;

  function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
    return (b == BW'(BANKS - 1)) ? '0 : b + 1'b1;
  endfunction

  assign wready_o  = (filled_q < (BW+1)'(BANKS));
  assign ravail_o  = (filled_q != '0);
  assign accept    = wvalid_i & wready_o;
  // A flush at address 0 still closes when it carries a byte in the same cycle.
  assign close     = (accept && (wr_addr_q == AW'(DEPTH - 1))) ||
                     (wflush_i && ((wr_addr_q != '0) || accept));
  assign close_len = {1'b0, wr_addr_q} + LW'(accept);
  assign rel       = rdone_i & ravail_o;

  assign wr_en_o   = accept;
  assign wr_bank_o = wr_bank_q;
  assign wr_addr_o = wr_addr_q;
  assign rd_bank_o = rd_bank_q;
  assign rlen_o    = ravail_o ? len_q[rd_bank_q] : '0;

  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_addr_d = wr_addr_q;
    filled_d  = filled_q;
    if (accept) wr_addr_d = wr_addr_q + 1'b1;
    if (close) begin
      wr_addr_d = '0;
      wr_bank_d = next_bank(wr_bank_q);
    end
    if (rel) rd_bank_d = next_bank(rd_bank_q);
    case ({close, rel})
      2'b10:   filled_d = filled_q + 1'b1;
      2'b01:   filled_d = filled_q - 1'b1;
      default: filled_d = filled_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      filled_q  <= '0;
      wr_addr_q <= '0;
      for (int b = 0; b < BANKS; b++) len_q[b] <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      filled_q  <= filled_d;
      wr_addr_q <= wr_addr_d;
      for (int b = 0; b < BANKS; b++) begin
        if (close && (wr_bank_q == BW'(b))) len_q[b] <= close_len;
      end
    end
  end

endmodule

// File: rtl/proj_fm_window_buf.sv
// N-bank FM genome window buffer: round-robin bank fill on a valid/ready port,
// one-cycle wrap-around window reads from the oldest filled bank.
module proj_fm_window_buf
  import proj_pkg::*;
#(
  parameter int BANKS     = FM_BANK_COUNT,
  parameter int DEPTH     = FM_BANK_DEPTH,
  parameter int DATA_BITS = FM_GENOME_BTYE,
  parameter int WINDOW    = FM_WINDOW_COUNT,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1,
  localparam int BW = $clog2(BANKS)
) (
  input  logic                        in_clk,
  input  logic                        in_rst,
  input  logic [DATA_BITS-1:0]        in_wdata,
  input  logic                        in_wvalid,
  output logic                        out_wready,
  input  logic                        in_wflush,
  output logic                        out_ravail,
  output logic [LW-1:0]               out_rlen,
  input  logic                        in_rreq,
  input  logic [AW-1:0]               in_raddr,
  output logic                        out_rvalid,
  output logic [WINDOW*DATA_BITS-1:0] out_rdata,
  input  logic                        in_rdone
);

  logic                        wr_en;
  logic [BW-1:0]               wr_bank, rd_bank;
  logic [AW-1:0]               wr_addr, idx;
  logic [DATA_BITS-1:0]        mem_q [BANKS][DEPTH];
  logic                        rvalid_q;
  logic [WINDOW*DATA_BITS-1:0] rdata_q, rdata_d;

  proj_fm_bank_ctrl #(.BANKS(BANKS), .DEPTH(DEPTH)) u_ctrl (
    .clk_i     (in_clk),
    .rst_i     (in_rst),
    .wvalid_i  (in_wvalid),
    .wflush_i  (in_wflush),
    .rdone_i   (in_rdone),
    .wready_o  (out_wready),
    .wr_en_o   (wr_en),
    .wr_bank_o (wr_bank),
    .wr_addr_o (wr_addr),
    .ravail_o  (out_ravail),
    .rd_bank_o (rd_bank),
    .rlen_o    (out_rlen)
  );

  always_ff @(posedge in_clk) begin
    if (wr_en) mem_q[wr_bank][wr_addr] <= in_wdata;
  end

  // Bytes past the bank's valid length read as zero rather than stale data.
  always_comb begin
    rdata_d = '0;
    idx     = '0;
    for (int i = 0; i < WINDOW; i++) begin
      idx = in_raddr + AW'(i);
      if ({1'b0, idx} < out_rlen) rdata_d[i*DATA_BITS +: DATA_BITS] = mem_q[rd_bank][idx];
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= in_rreq & out_ravail;
      if (in_rreq && out_ravail) rdata_q <= rdata_d;
    end
  end

  assign out_rvalid = rvalid_q;
  assign out_rdata  = rdata_q;

endmodule

// File: tb/tb_proj_fm_window_buf.sv
// Directed self-checking bench for proj_fm_window_buf (2 banks x 16 bytes, 4-byte window).
module tb_proj_fm_window_buf;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b1;
  logic [7:0]  in_wdata = '0;
  logic        in_wvalid = 1'b0;
  logic        out_wready;
  logic        in_wflush = 1'b0;
  logic        out_ravail;
  logic [4:0]  out_rlen;
  logic        in_rreq = 1'b0;
  logic [3:0]  in_raddr = '0;
  logic        out_rvalid;
  logic [31:0] out_rdata;
  logic        in_rdone = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  proj_fm_window_buf #(.BANKS(2), .DEPTH(16), .DATA_BITS(8), .WINDOW(4)) dut (
    .in_clk     (in_clk),
    .in_rst     (in_rst),
    .in_wdata   (in_wdata),
    .in_wvalid  (in_wvalid),
    .out_wready (out_wready),
    .in_wflush  (in_wflush),
    .out_ravail (out_ravail),
    .out_rlen   (out_rlen),
    .in_rreq    (in_rreq),
    .in_raddr   (in_raddr),
    .out_rvalid (out_rvalid),
    .out_rdata  (out_rdata),
    .in_rdone   (in_rdone)
  );

  always #5 in_clk = ~in_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    in_wdata  = d;
    in_wvalid = 1'b1;
    step();
    in_wvalid = 1'b0;
  endtask

  task automatic read_win(input string tag, input logic [3:0] a, input logic [31:0] exp);
    in_raddr = a;
    in_rreq  = 1'b1;
    step();
    in_rreq  = 1'b0;
    check_val({tag, "_rvalid"}, 32'(out_rvalid), 32'd1);
    check_val({tag, "_rdata"}, out_rdata, exp);
  endtask

  initial begin
    step();
    step();
    check_val("rst_wready", 32'(out_wready), 32'd1);
    check_val("rst_ravail", 32'(out_ravail), 32'd0);
    check_val("rst_rlen",   32'(out_rlen),   32'd0);
    check_val("rst_rvalid", 32'(out_rvalid), 32'd0);
    check_val("rst_rdata",  out_rdata,       32'd0);
    in_rst = 1'b0;
    step();

    // request with nothing filled is ignored
    in_rreq = 1'b1;
    step();
    in_rreq = 1'b0;
    check_val("empty_rreq_rvalid", 32'(out_rvalid), 32'd0);

    for (int i = 0; i < 16; i++) wr_byte(8'(i));
    check_val("fill_ravail", 32'(out_ravail), 32'd1);
    check_val("fill_rlen",   32'(out_rlen),   32'd16);
    check_val("fill_wready", 32'(out_wready), 32'd1);
    read_win("fill", 4'd2, 32'h05040302);
    step();
    check_val("fill_rvalid_drop", 32'(out_rvalid), 32'd0);
    read_win("wrap", 4'd14, 32'h01000F0E);

    // flush with a byte in the same cycle: 6 bytes in bank 1
    for (int i = 0; i < 5; i++) wr_byte(8'hA0 + 8'(i));
    in_wflush = 1'b1;
    wr_byte(8'hA5);
    in_wflush = 1'b0;
    check_val("flush_full_wready", 32'(out_wready), 32'd0);
    check_val("flush_old_rlen",    32'(out_rlen),   32'd16);
    in_rdone = 1'b1;
    step();
    in_rdone = 1'b0;
    check_val("flush_rlen",   32'(out_rlen),   32'd6);
    check_val("flush_wready", 32'(out_wready), 32'd1);
    read_win("flush", 4'd4, 32'h0000A5A4);
    read_win("flush_wrap", 4'd15, 32'hA2A1A000);

    in_rdone = 1'b1;
    step();
    in_rdone = 1'b0;
    check_val("drain_ravail", 32'(out_ravail), 32'd0);
    check_val("drain_rlen",   32'(out_rlen),   32'd0);

    // back-pressure: bank 0 = 0x40.., bank 1 = 0x50..
    for (int i = 0; i < 32; i++) wr_byte(8'h40 + 8'(i));
    check_val("bp_wready", 32'(out_wready), 32'd0);
    check_val("bp_ravail", 32'(out_ravail), 32'd1);
    wr_byte(8'hEE);
    check_val("bp_blocked_wready", 32'(out_wready), 32'd0);
    read_win("bp_bank0", 4'd12, 32'h4F4E4D4C);
    in_rdone = 1'b1;
    step();
    in_rdone = 1'b0;
    check_val("bp_rel_wready", 32'(out_wready), 32'd1);
    check_val("bp_rel_ravail", 32'(out_ravail), 32'd1);
    check_val("bp_rel_rlen",   32'(out_rlen),   32'd16);
    read_win("bp_bank1", 4'd0, 32'h53525150);

    // flush at address 0 with no byte does nothing
    in_wflush = 1'b1;
    step();
    in_wflush = 1'b0;
    check_val("idle_flush_wready", 32'(out_wready), 32'd1);
    check_val("idle_flush_rlen",   32'(out_rlen),   32'd16);

    // close bank 0 (3 bytes) and release bank 1 together
    wr_byte(8'h70);
    wr_byte(8'h71);
    in_wflush = 1'b1;
    in_rdone  = 1'b1;
    wr_byte(8'h72);
    in_wflush = 1'b0;
    in_rdone  = 1'b0;
    check_val("sim_ravail", 32'(out_ravail), 32'd1);
    check_val("sim_wready", 32'(out_wready), 32'd1);
    check_val("sim_rlen",   32'(out_rlen),   32'd3);
    read_win("sim", 4'd1, 32'h00007271);

    // reset in the cycle after an accepted request
    in_raddr = 4'd0;
    in_rreq  = 1'b1;
    step();
    in_rreq  = 1'b0;
    in_rst   = 1'b1;
    #1;
    check_val("mrst_rvalid", 32'(out_rvalid), 32'd0);
    check_val("mrst_rdata",  out_rdata,       32'd0);
    check_val("mrst_ravail", 32'(out_ravail), 32'd0);
    check_val("mrst_wready", 32'(out_wready), 32'd1);
    step();
    in_rst = 1'b0;
    step();
    check_val("mrst_after_rvalid", 32'(out_rvalid), 32'd0);
    in_wflush = 1'b1;
    step();
    in_wflush = 1'b0;
    check_val("mrst_flush_ravail", 32'(out_ravail), 32'd0);
    check_val("mrst_flush_wready", 32'(out_wready), 32'd1);

    // single-byte flush at address 0
    in_wflush = 1'b1;
    wr_byte(8'h99);
    in_wflush = 1'b0;
    check_val("one_rlen", 32'(out_rlen), 32'd1);
    read_win("one", 4'd0, 32'h00000099);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
